// File: rtl/rpn_stack_sequencer_pkg.sv
// Shared definitions for the RPN command sequencer: op codes, error codes and
// the sequencer FSM state encoding.
package rpn_stack_sequencer_pkg;

  localparam logic [2:0] OP_PUSH = 3'd0;
  localparam logic [2:0] OP_POP  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_DUP  = 3'd4;
  localparam logic [2:0] OP_SWAP = 3'd5;
  localparam logic [2:0] OP_NOP  = 3'd6;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_UNDERFLOW = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW  = 2'd2;
  localparam logic [1:0] ERR_FAULT     = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_A,
    ST_CAP_A,
    ST_RD_B,
    ST_CAP_B,
    ST_WR_1,
    ST_WR_2
  } state_t;

endpackage

// File: rtl/rpn_alu.sv
// Combinational WL-bit add/subtract of the two stack operands.
// b is the element below the old top a; results wrap modulo 2^WL.
module rpn_alu
  import rpn_stack_sequencer_pkg::*;
#(
  parameter int WL = 4
) (
  input  logic [2:0]    op,
  input  logic [WL-1:0] a,
  input  logic [WL-1:0] b,
  output logic [WL-1:0] y
);

  always_comb begin
    y = b + a;
    if (op == OP_SUB) y = b - a;
  end

endmodule

// File: rtl/rpn_stack_sequencer.sv
// Expands RPN commands into single-cycle push/pop requests to the LIFO stack,
// performs the arithmetic and reports results, rejections and stack faults.
//
// state    | meaning
// IDLE     | ready for a command, pre-checks against level
// RD_A     | pop request for operand a (old top)
// CAP_A    | s_dout holds a; POP result presented here
// RD_B     | pop request for operand b
// CAP_B    | s_dout holds b
// WR_1     | first push (data, result, or a)
// WR_2     | second push for DUP / SWAP
module rpn_stack_sequencer
  import rpn_stack_sequencer_pkg::*;
#(
  parameter int WL    = 4,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [2:0]                 cmd_op,
  input  logic [WL-1:0]              cmd_data,
  output logic                       res_valid,
  output logic [WL-1:0]              res_data,
  output logic                       err,
  output logic [1:0]                 err_code,
  output logic                       fault,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       s_rreq,
  output logic                       s_wreq,
  output logic [WL-1:0]              s_din,
  input  logic [WL-1:0]              s_dout,
  input  logic                       s_full,
  input  logic                       s_empty,
  input  logic                       s_error
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [LW-1:0] LVL_TWO  = LW'(2);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  state_t        state, next_state;
  logic [2:0]    op_q;
  logic [WL-1:0] a_q, b_q, res_q;
  logic [LW-1:0] level_q;
  logic          req_seen, wr_seen;

  logic          underflow, overflow;
  logic          next_rd, next_wr;
  logic [WL-1:0] a_cur, b_cur, alu_y, din_next;
  logic          stack_err_seen, flag_mismatch;

  assign underflow = (((cmd_op == OP_POP) || (cmd_op == OP_DUP)) && (level_q < LVL_ONE)) ||
                     (((cmd_op == OP_ADD) || (cmd_op == OP_SUB) || (cmd_op == OP_SWAP)) &&
                      (level_q < LVL_TWO));
  assign overflow  = ((cmd_op == OP_PUSH) || (cmd_op == OP_DUP)) && (level_q >= LVL_FULL);

  // state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= ST_IDLE;
    else      state <= next_state;
  end

  // next state
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (cmd_valid && !underflow && !overflow) begin
          case (cmd_op)
            OP_PUSH:                            next_state = ST_WR_1;
            OP_POP, OP_ADD, OP_SUB, OP_DUP, OP_SWAP: next_state = ST_RD_A;
            default:                            next_state = ST_IDLE;
          endcase
        end
      end
      ST_RD_A:  next_state = ST_CAP_A;
      ST_CAP_A: begin
        case (op_q)
          OP_POP:  next_state = ST_IDLE;
          OP_DUP:  next_state = ST_WR_1;
          default: next_state = ST_RD_B;
        endcase
      end
      ST_RD_B:  next_state = ST_CAP_B;
      ST_CAP_B: next_state = ST_WR_1;
      ST_WR_1:  next_state = ((op_q == OP_DUP) || (op_q == OP_SWAP)) ? ST_WR_2 : ST_IDLE;
      ST_WR_2:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // outputs; the POP result is presented straight from s_dout in CAP_A
  always_comb begin
    cmd_ready = (state == ST_IDLE);
    res_valid = (state == ST_CAP_A) && (op_q == OP_POP);
    res_data  = res_valid ? s_dout : res_q;
    level     = level_q;
  end

  assign next_rd = (next_state == ST_RD_A) || (next_state == ST_RD_B);
  assign next_wr = (next_state == ST_WR_1) || (next_state == ST_WR_2);

  // Operands are taken from s_dout in the cycle they arrive so WR_1 can
  // follow CAP_x directly without an extra latch cycle.
  assign a_cur = (state == ST_CAP_A) ? s_dout : a_q;
  assign b_cur = (state == ST_CAP_B) ? s_dout : b_q;

  rpn_alu #(.WL(WL)) u_alu (
    .op (op_q),
    .a  (a_cur),
    .b  (b_cur),
    .y  (alu_y)
  );

  always_comb begin
    din_next = s_din;
    if (next_state == ST_WR_1) begin
      if (state == ST_IDLE)                             din_next = cmd_data;
      else if ((op_q == OP_ADD) || (op_q == OP_SUB))    din_next = alu_y;
      else                                              din_next = a_cur;
    end else if (next_state == ST_WR_2) begin
      din_next = (op_q == OP_DUP) ? a_q : b_q;
    end
  end

  assign stack_err_seen = s_error && ((state == ST_CAP_A) || (state == ST_CAP_B) || wr_seen);

  // Stack flags lag a request by one cycle, hence the req_seen mask.
  assign flag_mismatch = (state == ST_IDLE) && !req_seen &&
                         (((level_q == '0) != s_empty) || ((level_q == LVL_FULL) != s_full));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s_rreq   <= 1'b0;
      s_wreq   <= 1'b0;
      s_din    <= '0;
      req_seen <= 1'b0;
      wr_seen  <= 1'b0;
      level_q  <= '0;
      op_q     <= OP_NOP;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
      fault    <= 1'b0;
    end else begin
      s_rreq   <= next_rd;
      s_wreq   <= next_wr;
      s_din    <= din_next;
      req_seen <= s_rreq || s_wreq;
      wr_seen  <= s_wreq;
      if (next_rd)      level_q <= level_q - LVL_ONE;
      else if (next_wr) level_q <= level_q + LVL_ONE;
      if ((state == ST_IDLE) && cmd_valid) op_q <= cmd_op;
      if (state == ST_CAP_A) a_q <= s_dout;
      if (state == ST_CAP_B) b_q <= s_dout;
      if (res_valid) res_q <= s_dout;
      if (stack_err_seen) begin
        err      <= 1'b1;
        err_code <= ERR_FAULT;
      end else if ((state == ST_IDLE) && cmd_valid && (underflow || overflow)) begin
        err      <= 1'b1;
        err_code <= underflow ? ERR_UNDERFLOW : ERR_OVERFLOW;
      end else begin
        err      <= 1'b0;
        err_code <= ERR_NONE;
      end
      fault <= fault || stack_err_seen || flag_mismatch;
    end
  end

endmodule

// File: tb/tb_rpn_stack_sequencer.sv
// Scoreboard bench: a queue-based RPN stack model predicts writes, results and
// errors; a negedge monitor compares them as the DUT presents them.
module tb_rpn_stack_sequencer;

  localparam int WL    = 4;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = 3'd6;
  logic [WL-1:0] cmd_data = '0;
  logic          res_valid;
  logic [WL-1:0] res_data;
  logic          err;
  logic [1:0]    err_code;
  logic          fault;
  logic [LW-1:0] level;
  logic          s_rreq, s_wreq;
  logic [WL-1:0] s_din;
  logic [WL-1:0] s_dout;
  logic          s_full, s_empty;
  logic          s_error = 1'b0;

  rpn_stack_sequencer #(.WL(WL), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .res_valid(res_valid), .res_data(res_data),
    .err(err), .err_code(err_code), .fault(fault), .level(level),
    .s_rreq(s_rreq), .s_wreq(s_wreq), .s_din(s_din), .s_dout(s_dout),
    .s_full(s_full), .s_empty(s_empty), .s_error(s_error)
  );

  always #5 CLK = ~CLK;

  // stack environment (the LIFO block the sequencer drives)
  logic [WL-1:0] env_mem [DEPTH];
  int env_cnt;
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      env_cnt <= 0;
      s_dout  <= '0;
    end else if (s_wreq && env_cnt < DEPTH) begin
      env_mem[env_cnt] <= s_din;
      env_cnt <= env_cnt + 1;
    end else if (s_rreq && env_cnt > 0) begin
      s_dout  <= env_mem[env_cnt-1];
      env_cnt <= env_cnt - 1;
    end
  end
  assign s_empty = (env_cnt == 0);
  assign s_full  = (env_cnt == DEPTH);

  typedef struct { int kind; int val; } ev_t;   // kind: 0 write, 1 result, 2 error
  ev_t exp_q[$];
  int  ref_stk[$];
  int  checks = 0, errors = 0;
  int  exp_rd = 0, act_rd = 0, last_res = 0;
  bit  exp_fault = 0;

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic expect_ev(input int kind, input int val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic match(input int kind, input int val);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d value %0d, expected none", kind, val);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val) begin
        errors++;
        $display("FAIL event: got kind %0d value %0d, expected kind %0d value %0d",
                 kind, val, e.kind, e.val);
      end
    end
  endtask

  // reference RPN semantics; returns expected busy cycles
  task automatic model(input int op, input int data, output int busy);
    int n, a, b, r;
    n = ref_stk.size();
    busy = 0;
    case (op)
      0: if (n < DEPTH) begin expect_ev(0, data); ref_stk.push_back(data); busy = 1; end
         else expect_ev(2, 2);
      1: if (n >= 1) begin
           a = ref_stk.pop_back(); expect_ev(1, a); exp_rd += 1; busy = 2;
         end else expect_ev(2, 1);
      2, 3: if (n >= 2) begin
           a = ref_stk.pop_back(); b = ref_stk.pop_back();
           r = (op == 2) ? (b + a) % 16 : (b - a + 16) % 16;
           ref_stk.push_back(r); expect_ev(0, r); exp_rd += 2; busy = 5;
         end else expect_ev(2, 1);
      4: if (n < 1) expect_ev(2, 1);
         else if (n >= DEPTH) expect_ev(2, 2);
         else begin
           a = ref_stk[n-1]; ref_stk.push_back(a);
           expect_ev(0, a); expect_ev(0, a); exp_rd += 1; busy = 4;
         end
      5: if (n >= 2) begin
           a = ref_stk.pop_back(); b = ref_stk.pop_back();
           ref_stk.push_back(a); ref_stk.push_back(b);
           expect_ev(0, a); expect_ev(0, b); exp_rd += 2; busy = 6;
         end else expect_ev(2, 1);
      default: busy = 0;
    endcase
  endtask

  task automatic issue(input int op, input int data, input bit inject);
    int busy_exp, busy;
    bit done;
    @(negedge CLK);
    model(op, data, busy_exp);
    if (inject) begin expect_ev(2, 3); exp_fault = 1; end
    cmd_valid = 1'b1;
    cmd_op    = 3'(op);
    cmd_data  = WL'(data);
    @(posedge CLK);
    #1 cmd_valid = 1'b0;
    if (inject) begin
      @(posedge CLK); #1 s_error = 1'b1;
      @(posedge CLK); #1 s_error = 1'b0;
    end
    busy = 0;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge CLK);
      if (cmd_ready) done = 1;
      else busy++;
    end
    check("cmd_done_in_time", int'(done), 1);
    if (!inject) check($sformatf("busy_cycles_op%0d", op), busy, busy_exp);
    check("level", int'(level), ref_stk.size());
    check("pop_requests", act_rd, exp_rd);
    check("fault", int'(fault), int'(exp_fault));
  endtask

  always @(negedge CLK) begin
    if (RST) begin
      if (s_rreq) act_rd++;
      if (s_rreq || s_wreq) check("req_exclusive", int'(s_rreq && s_wreq), 0);
      if (s_wreq) match(0, int'(s_din));
      if (res_valid) begin
        match(1, int'(res_data));
        last_res = int'(res_data);
      end else check("res_hold", int'(res_data), last_res);
      if (err) match(2, int'(err_code));
    end
  end

  initial begin
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_cmd_ready", int'(cmd_ready), 1);
    check("rst_level", int'(level), 0);
    check("rst_outputs", int'({s_rreq, s_wreq, s_din, res_valid, res_data, err, err_code, fault}), 0);
    RST = 1'b1;

    issue(0, 3, 0); issue(0, 5, 0); issue(3, 0, 0); issue(1, 0, 0);
    issue(0, 9, 0); issue(0, 9, 0); issue(2, 0, 0); issue(1, 0, 0);
    issue(0, 1, 0); issue(0, 2, 0); issue(5, 0, 0); issue(1, 0, 0); issue(1, 0, 0);
    for (int i = 0; i < DEPTH; i++) issue(0, $urandom_range(0, 15), 0);
    issue(0, 7, 0); issue(4, 0, 0);
    for (int i = 0; i < DEPTH; i++) issue(1, 0, 0);
    issue(1, 0, 0); issue(0, 4, 0); issue(2, 0, 0); issue(6, 0, 0);

    for (int i = 0; i < 300; i++) issue($urandom_range(0, 7), $urandom_range(0, 15), 0);

    while (ref_stk.size() > 0) issue(1, 0, 0);
    issue(0, 4, 0);
    issue(1, 0, 1);
    issue(0, 6, 0); issue(4, 0, 0); issue(7, 0, 0);

    // reset in the middle of a DUP (CAP_A cycle)
    @(negedge CLK);
    cmd_valid = 1'b1; cmd_op = 3'd4;
    @(posedge CLK); #1 cmd_valid = 1'b0;
    @(negedge CLK);
    check("dup_busy_before_reset", int'(cmd_ready), 0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    exp_q.delete(); ref_stk.delete();
    exp_rd = 0; act_rd = 0; last_res = 0; exp_fault = 0;
    check("midseq_rst_outputs", int'({s_rreq, s_wreq, s_din, res_valid, res_data, err, err_code, fault}), 0);
    check("midseq_rst_level", int'(level), 0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("post_rst_cmd_ready", int'(cmd_ready), 1);
    check("post_rst_level", int'(level), 0);
    check("post_rst_fault", int'(fault), 0);
    issue(0, 11, 0); issue(4, 0, 0); issue(2, 0, 0); issue(1, 0, 0);

    repeat (3) @(negedge CLK);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
